// File: rtl/jk_pkg.sv
// Shared types and constants for the jkff stimulus command player.
package jk_pkg;

    localparam int unsigned JK_HOLD_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } jk_state_e;

    typedef struct packed {
        logic                 j;
        logic                 k;
        logic [JK_HOLD_W-1:0] hold;
    } jk_cmd_t;

    // {j,k} encodings as seen by the flip-flop
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cmd_fifo.sv
// Command FIFO: synchronous write, combinational read of the head entry.
module jk_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10,
    parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [LW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // A full FIFO refuses a push even when a pop happens in the same cycle
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/jk_seq_gen.sv
// Plays queued {j,k,hold} commands onto registered jkff j/k inputs.
module jk_seq_gen
    import jk_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_j,
    input  logic                         cmd_k,
    input  logic [HOLD_W-1:0]            cmd_hold,
    input  logic                         enable,
    output logic                         j,
    output logic                         k,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned CW = 2 + HOLD_W;

    typedef struct packed {
        logic              j;
        logic              k;
        logic [HOLD_W-1:0] hold;
    } cmd_t;

    jk_state_e         state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              j_q, j_d;
    logic              k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     rdata;
    cmd_t              head;
    logic [HOLD_W-1:0] head_hold;

    jk_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid),
        .wdata ({cmd_j, cmd_k, cmd_hold}),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign cmd_ready = !full;
    assign head      = rdata;
    // A zero hold plays for one cycle, same as hold=1
    assign head_hold = (head.hold == '0) ? HOLD_W'(1) : head.hold;

    assign j    = j_q;
    assign k    = k_q;
    assign busy = busy_q;
    assign done = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            j_q     <= j_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        j_d     = j_q;
        k_d     = k_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                {j_d, k_d} = JK_HOLD;
                busy_d     = 1'b0;
                if (enable && !empty) begin
                    pop     = 1'b1;
                    j_d     = head.j;
                    k_d     = head.k;
                    cnt_d   = head_hold;
                    busy_d  = 1'b1;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (cnt_q > HOLD_W'(1)) begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end else if (enable && !empty) begin
                    // Back-to-back: next command lands on the same edge
                    pop   = 1'b1;
                    j_d   = head.j;
                    k_d   = head.k;
                    cnt_d = head_hold;
                end else begin
                    {j_d, k_d} = JK_HOLD;
                    cnt_d      = '0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_jk_seq_gen.sv
// Directed bench for jk_seq_gen with a behavioural jkff on its j/k outputs.
module tb_jk_seq_gen;
    import jk_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_j;
    logic       cmd_k;
    logic [7:0] cmd_hold;
    logic       enable;
    logic       j;
    logic       k;
    logic       busy;
    logic       done;
    logic [2:0] level;
    logic       q;

    int vectors = 0;
    int errors  = 0;

    jk_seq_gen #(.DEPTH(4), .HOLD_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_j     (cmd_j),
        .cmd_k     (cmd_k),
        .cmd_hold  (cmd_hold),
        .enable    (enable),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference jkff fed by the generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= 1'b0;
        else begin
            case ({j, k})
                JK_RESET:  q <= 1'b0;
                JK_SET:    q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

    // Present one command for a single accepting edge; returns at the next negedge
    task automatic push(input logic pj, input logic pk, input logic [7:0] ph);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL push_ready_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        cmd_j = pj; cmd_k = pk; cmd_hold = ph; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        push(1'b1, 1'b1, 8'd10);
        push(1'b1, 1'b0, 8'd3);
        @(negedge clk);
        vectors++;
        if ({j, k, busy} !== 3'b111) begin
            errors++;
            $display("FAIL reset_pre_play: jkbusy=%b required 111", {j, k, busy});
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({j, k, busy, done} !== 4'b0000 || level !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_immediate: jkbusydone=%b level=%0d ready=%b required 0000/0/1",
                     {j, k, busy, done}, level, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b0000 || level !== 3'd0) begin
            errors++;
            $display("FAIL reset_no_pop: jkbusydone=%b level=%0d required 0000/0",
                     {j, k, busy, done}, level);
        end
    endtask

    task automatic test_single();
        enable = 1'b1;
        push(1'b1, 1'b0, 8'd3);
        vectors++;
        if ({j, k, busy} !== 3'b000 || level !== 3'd1) begin
            errors++;
            $display("FAIL single_latency: jkbusy=%b level=%0d required 000/1", {j, k, busy}, level);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({j, k, busy, done} !== 4'b1010) begin
                errors++;
                $display("FAIL single_play%0d: jkbusydone=%b required 1010", i, {j, k, busy, done});
            end
        end
        @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL single_done: jkbusydone=%b required 0001", {j, k, busy, done});
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width: done=%b required 0", done);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_jk [8];
        logic       exp_q  [8];
        exp_jk = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
        exp_q  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 1'b0, 8'd2);
        push(1'b0, 1'b1, 8'd1);
        push(1'b1, 1'b1, 8'd4);
        vectors++;
        if (level !== 3'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_queued: level=%0d busy=%b required 3/0", level, busy);
        end
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if ({j, k} !== exp_jk[i] || done !== (i == 7) || busy !== (i != 7) || q !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_step%0d: jk=%b done=%b busy=%b q=%b required jk=%b done=%b busy=%b q=%b",
                         i, {j, k}, done, busy, q, exp_jk[i], (i == 7), (i != 7), exp_q[i]);
            end
        end
    endtask

    task automatic test_full();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 8'd2);
        vectors++;
        if (level !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ready=%b required 4/0", level, cmd_ready);
        end
        cmd_j = 1'b0; cmd_k = 1'b1; cmd_hold = 8'd1; cmd_valid = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (level !== 3'd4 || cmd_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse: level=%0d ready=%b busy=%b required 4/0/0", level, cmd_ready, busy);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if (level !== 3'd3 || cmd_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_pop: level=%0d ready=%b busy=%b required 3/1/1", level, cmd_ready, busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (level !== 3'd4) begin
            errors++;
            $display("FAIL full_fifth_accept: level=%0d required 4", level);
        end
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || level !== 3'd0 || done !== 1'b1) begin
            errors++;
            $display("FAIL full_drain: busy=%b level=%0d done=%b required 0/0/1", busy, level, done);
        end
    endtask

    task automatic test_hold0_enable();
        enable = 1'b1;
        @(negedge clk);
        push(1'b1, 1'b1, 8'd0);
        @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b1110) begin
            errors++;
            $display("FAIL hold0_play: jkbusydone=%b required 1110", {j, k, busy, done});
        end
        @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL hold0_done: jkbusydone=%b required 0001", {j, k, busy, done});
        end
        cmd_j = 1'b1; cmd_k = 1'b0; cmd_hold = 8'd5; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_j = 1'b0; cmd_k = 1'b1; cmd_hold = 8'd1;
        vectors++;
        if (level !== 3'd1) begin
            errors++;
            $display("FAIL gate_first_push: level=%0d required 1", level);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (level !== 3'd1 || {j, k} !== 2'b10) begin
            errors++;
            $display("FAIL gate_push_pop: level=%0d jk=%b required 1/10", level, {j, k});
        end
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({j, k, busy, done} !== 4'b1010) begin
                errors++;
                $display("FAIL gate_hold%0d: jkbusydone=%b required 1010", i, {j, k, busy, done});
            end
        end
        @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b0001 || level !== 3'd1) begin
            errors++;
            $display("FAIL gate_done: jkbusydone=%b level=%0d required 0001/1", {j, k, busy, done}, level);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || level !== 3'd1) begin
            errors++;
            $display("FAIL gate_no_pop: busy=%b level=%0d required 0/1", busy, level);
        end
        enable = 1'b1;
        @(negedge clk);
        vectors++;
        if ({j, k, busy} !== 3'b011 || level !== 3'd0) begin
            errors++;
            $display("FAIL gate_resume: jkbusy=%b level=%0d required 011/0", {j, k, busy}, level);
        end
        @(negedge clk);
        vectors++;
        if ({j, k, busy, done} !== 4'b0001) begin
            errors++;
            $display("FAIL gate_final: jkbusydone=%b required 0001", {j, k, busy, done});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_j = 1'b0;
        cmd_k = 1'b0;
        cmd_hold = 8'd0;
        enable = 1'b0;
        #1;
        vectors++;
        if ({j, k, busy, done} !== 4'b0000 || level !== 3'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: jkbusydone=%b level=%0d ready=%b required 0000/0/1",
                     {j, k, busy, done}, level, cmd_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_hold0_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/jk_seq_gen.md
Name: jk_seq_gen

Overview:
- Upstream stimulus stage for jkff. Accepts a queue of {j, k, hold} commands over a valid/ready handshake and drives the jkff j/k inputs.
- Each command's j/k pair is held for a programmed number of clk cycles.
- This replaces hand-timed j/k sequences with a reusable, clocked command player that feeds the flip-flop directly.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- HOLD_W, 8, width of per-command hold count in clk cycles

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present on cmd_j/cmd_k/cmd_hold
- cmd_ready  out  1  FIFO can accept a command (= !full)
- cmd_j  in  1  j value of command
- cmd_k  in  1  k value of command
- cmd_hold  in  HOLD_W  cycles to hold j/k (0 treated as 1)
- enable  in  1  permit popping new commands
- j  out  1  registered j to jkff
- k  out  1  registered k to jkff
- busy  out  1  a command is currently being played
- done  out  1  one-cycle pulse when the last queued command finishes
- level  out  $clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, level=0, cmd_ready=1, j=0, k=0, busy=0, done=0, state IDLE, hold counter=0. Outputs take reset values immediately, not at the next edge.
- Push: on a clk edge with cmd_valid && cmd_ready, write {cmd_j, cmd_k, cmd_hold} at the write pointer. Pointers wrap modulo DEPTH.
- cmd_ready is purely !full. When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop (not full, not empty): level is unchanged.
- State IDLE:
  - j=0, k=0 (jkff hold), busy=0.
  - If enable && !empty at an edge: pop head, register j/k from it, load cnt = max(hold,1), go to PLAY, busy=1.
- State PLAY:
  - j/k stay constant. cnt decrements by 1 each edge while cnt>1.
  - At an edge with cnt==1 and enable && !empty: pop the next command back-to-back. j/k and cnt update at that same edge with no idle gap.
  - At an edge with cnt==1 otherwise: go to IDLE, j=k=0, busy=0, done=1 for exactly one cycle.
- Latency:
  - A command pushed at edge N into an empty FIFO in IDLE with enable=1 appears on j/k after edge N+1.
  - A command is driven for exactly max(hold,1) cycles.
- enable deasserted mid-PLAY: the current command runs to completion and no further pop occurs. After completion the block goes to IDLE and done pulses.
- enable reasserted with a non-empty FIFO while IDLE: pop at the next edge.
- done does not pulse when a command is followed back-to-back by another.
- done does not pulse if reset interrupts a command.
- hold=0 is identical to hold=1.
- cnt width is HOLD_W. There is no overflow path, since max load is 2^HOLD_W-1.
- All outputs are registered except cmd_ready and level, which are combinational from registered pointers/count.

Decomposition:
- Shared package jk_pkg:
  - typedef jk_cmd_t = packed struct {j, k, hold[HOLD_W-1:0]}
  - state enum {IDLE, PLAY}
  - constants JK_HOLD = 2'b00, JK_RESET = 2'b01, JK_SET = 2'b10, JK_TOGGLE = 2'b11 (the {j,k} pair)
- One sub-module: jk_cmd_fifo.
  - Synchronous-write, combinational-read FIFO with DEPTH/width parameters and push/pop/full/empty/level.
  - Same clk/rst_n.
- Top level holds the FSM, hold counter and j/k registers.

Test Plan:
- Reset check: assert rst_n=0 mid-PLAY with j=1,k=1 -> j=0, k=0, busy=0, level=0, cmd_ready=1 immediately. After release, no pop occurs until a new push.
- Single command: push {1,0,hold=3} with enable=1 -> j=1,k=0 for exactly 3 cycles starting one edge after the push. Then j=k=0 and done pulses once.
- Back-to-back: push {1,0,2}, {0,1,1}, {1,1,4} -> j/k sequence 10,10,01,11,11,11,11 with no gap. done pulses once, after the last cycle. Drive a jkff instance from j/k: q rises to 1 during 10, falls to 0 during 01, then toggles every cycle during 11.
- Full/backpressure: enable=0, push 5 commands -> cmd_ready=0 after the 4th push and level=4. The 5th command is held by the source and accepted only after one pop once enable=1.
- Hold=0 and enable gating: push {1,1,0} -> played for 1 cycle. Push {1,0,5}, then drop enable in its cycle 2 -> the command completes all 5 cycles and a queued {0,1,1} is not popped until enable=1.
